flash_read_ctrl: RTL and testbench

FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

---
 rtl/flash_pkg.sv | 33 +++
 rtl/flash_read_ctrl_if.sv | 31 +++
 rtl/flash_read_ctrl_spi_sck_gen.sv | 35 +++
 rtl/flash_read_ctrl.sv | 166 ++++++++++++++++
 tb/tb_flash_read_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash controller family: state encoding,
// flash opcodes and chip-select guard timing.
package flash_pkg;

   // Controller state encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_CMD   = 3'd2,
      ST_ADDR  = 3'd3,
      ST_READ  = 3'd4,
      ST_HOLD  = 3'd5
   } state_t;

   // Flash opcodes (READ used here, the others by sibling controllers)
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_SE   = 8'hD8;

   // sys_clk cycles with cs_n low and sck idle before the command and after the data
   localparam int unsigned GUARD_CYC = 4;

   // Serial frame lengths
   localparam int unsigned CMD_BITS  = 8;
   localparam int unsigned ADDR_BITS = 24;

   // States in which the SPI bit clock runs
   function automatic logic is_shift_state(input state_t s);
      return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ);
   endfunction

endpackage

// File: rtl/flash_read_ctrl_if.sv
// Bundle of the key trigger, SPI pins and received-byte stream of the flash
// read controller. master = controller side, slave = flash/consumer side.
interface flash_read_ctrl_if;
   logic       key_flag;
   logic       miso;
   logic       cs_n;
   logic       sck;
   logic       mosi;
   logic [7:0] rd_data;
   logic       rd_valid;

   modport master (
      input  key_flag,
      input  miso,
      output cs_n,
      output sck,
      output mosi,
      output rd_data,
      output rd_valid
   );

   modport slave (
      output key_flag,
      output miso,
      input  cs_n,
      input  sck,
      input  mosi,
      input  rd_data,
      input  rd_valid
   );
endinterface

// File: rtl/flash_read_ctrl_spi_sck_gen.sv
// SPI mode-0 bit clock: a 2-bit phase counter runs while enabled, one SPI bit
// spans four sys_clk, and sck is high in phases 2 and 3.
module spi_sck_gen (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       enable,
   output logic [1:0] cnt_clk,
   output logic       sck
);

   logic [1:0] cnt_clk_q;
   logic [1:0] cnt_clk_d;

   // Advance the phase while shifting; park at 0 otherwise so every frame starts at phase 0
   always_comb begin
      cnt_clk_d = 2'd0;
      if (enable) begin
         cnt_clk_d = cnt_clk_q + 2'd1;
      end
   end

   // Phase counter register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_clk_q <= 2'd0;
      end else begin
         cnt_clk_q <= cnt_clk_d;
      end
   end

   assign cnt_clk = cnt_clk_q;
   // Taken straight from a flop bit: glitch-free and low whenever the counter is parked
   assign sck     = cnt_clk_q[1];

endmodule

// File: rtl/flash_read_ctrl.sv
// SPI flash sequential reader: on a key pulse, selects the flash, sends READ
// (0x03) plus a 24-bit address, then shifts in RD_NUM bytes, presenting each
// one on rd_data with a single-cycle rd_valid strobe.
module flash_read_ctrl
   import flash_pkg::*;
#(
   parameter logic [23:0] RD_ADDR = 24'h00_00_00,
   parameter int unsigned RD_NUM  = 10
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   flash_read_ctrl_if.master  bus
);

   localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYC - 1);
   localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
   localparam logic [4:0] ADDR_LAST  = 5'(CMD_BITS + ADDR_BITS - 1);
   localparam logic [7:0] LAST_BYTE  = 8'(RD_NUM - 1);

   state_t      state_q, state_d;
   logic [1:0]  guard_q, guard_d;
   logic [31:0] tx_q, tx_d;
   logic [4:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  rx_q, rx_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        cs_n_q, cs_n_d;
   logic        mosi_q, mosi_d;

   logic        enable;
   logic [1:0]  cnt_clk;
   logic        sck;
   logic        bit_end;
   logic        sample;

   spi_sck_gen u_sck_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .enable    (enable),
      .cnt_clk   (cnt_clk),
      .sck       (sck)
   );

   assign bit_end = (cnt_clk == 2'd3);
   assign sample  = (state_q == ST_READ) && (cnt_clk == 2'd2);

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the key is only honoured from IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.key_flag)                                   state_d = ST_SETUP;
         ST_SETUP: if (guard_q == GUARD_LAST)                          state_d = ST_CMD;
         ST_CMD:   if (bit_end && (tx_bit_q == CMD_LAST))              state_d = ST_ADDR;
         ST_ADDR:  if (bit_end && (tx_bit_q == ADDR_LAST))             state_d = ST_READ;
         ST_READ:  if (bit_end && (bit_q == 3'd7) && (byte_q == LAST_BYTE)) state_d = ST_HOLD;
         ST_HOLD:  if (guard_q == GUARD_LAST)                          state_d = ST_IDLE;
         default:                                                      state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs: the bit clock runs only in the shift states
   always_comb begin
      enable = is_shift_state(state_q);
   end

   // Counters, shift registers and the next values of the registered pins
   always_comb begin
      guard_d    = 2'd0;
      tx_d       = tx_q;
      tx_bit_d   = tx_bit_q;
      rx_d       = rx_q;
      bit_d      = 3'd0;
      byte_d     = 8'd0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d     = '0;
            tx_bit_d = '0;
            rx_d     = '0;
         end
         ST_SETUP: begin
            guard_d  = guard_q + 2'd1;
            tx_d     = {OP_READ, RD_ADDR};
            tx_bit_d = '0;
         end
         ST_CMD, ST_ADDR: begin
            // Next bit is presented at phase 0, i.e. right after phase 3
            if (bit_end) begin
               tx_d     = {tx_q[30:0], 1'b0};
               tx_bit_d = tx_bit_q + 5'd1;
            end
         end
         ST_READ: begin
            bit_d  = bit_q;
            byte_d = byte_q;
            if (sample) begin
               rx_d = {rx_q[6:0], bus.miso};
               if (bit_q == 3'd7) begin
                  rd_data_d  = {rx_q[6:0], bus.miso};
                  rd_valid_d = 1'b1;
               end
            end
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               // Byte counter saturates at the last byte; the FSM leaves READ there
               if ((bit_q == 3'd7) && (byte_q != LAST_BYTE)) begin
                  byte_d = byte_q + 8'd1;
               end
            end
         end
         ST_HOLD: begin
            guard_d = guard_q + 2'd1;
         end
         default: ;
      endcase
      // Pins registered from next-state values so they carry no decode glitches
      cs_n_d = (state_d == ST_IDLE);
      mosi_d = ((state_d == ST_CMD) || (state_d == ST_ADDR)) ? tx_d[31] : 1'b0;
   end

   // Datapath and pin registers; reset deselects the flash immediately
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         guard_q    <= 2'd0;
         tx_q       <= '0;
         tx_bit_q   <= '0;
         rx_q       <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         guard_q    <= guard_d;
         tx_q       <= tx_d;
         tx_bit_q   <= tx_bit_d;
         rx_q       <= rx_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
   end

   assign bus.cs_n     = cs_n_q;
   assign bus.sck      = sck;
   assign bus.mosi     = mosi_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl: two instances (10 bytes @ 0x000000 and
// 1 byte @ 0x123456) against a small mode-0 flash model on a 50 MHz clock.
`timescale 1ns/1ps
module tb_flash_read_ctrl;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   always #10 sys_clk = ~sys_clk;

   flash_read_ctrl_if bus_a ();
   flash_read_ctrl_if bus_b ();

   flash_read_ctrl #(.RD_ADDR(24'h00_00_00), .RD_NUM(10)) dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_a)
   );

   flash_read_ctrl #(.RD_ADDR(24'h12_34_56), .RD_NUM(1)) dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_b)
   );

   // Flat per-instance views: index 0 = dut_a, 1 = dut_b
   logic       cs_n_s [2];
   logic       sck_s  [2];
   logic       mosi_s [2];
   logic       vld_s  [2];
   logic [7:0] data_s [2];
   logic       miso_s [2] = '{1'b0, 1'b0};
   logic       key_s  [2] = '{1'b0, 1'b0};

   assign cs_n_s[0] = bus_a.cs_n;     assign cs_n_s[1] = bus_b.cs_n;
   assign sck_s[0]  = bus_a.sck;      assign sck_s[1]  = bus_b.sck;
   assign mosi_s[0] = bus_a.mosi;     assign mosi_s[1] = bus_b.mosi;
   assign vld_s[0]  = bus_a.rd_valid; assign vld_s[1]  = bus_b.rd_valid;
   assign data_s[0] = bus_a.rd_data;  assign data_s[1] = bus_b.rd_data;
   assign bus_a.miso = miso_s[0];     assign bus_b.miso = miso_s[1];
   assign bus_a.key_flag = key_s[0];  assign bus_b.key_flag = key_s[1];

   // Bytes the flash model returns, in order
   logic [7:0] pat [16] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E,
                            8'h01, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int run [2], since_hi [2], last_len [2], last_since [2], txn [2];
   int vcnt [2], idx [2], first_vld [2], prev_vld [2];
   int sck_hi [2], last_sck_hi [2], rises [2], falls [2], viol [2];
   logic [31:0] cap [2];
   logic prev_sck [2], prev_mosi [2];
   int j;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor + flash model, sampled mid-cycle
   always @(negedge sys_clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!cs_n_s[i]) begin
            if (run[i] == 0) begin
               idx[i] = 0; cap[i] = '0; rises[i] = 0; sck_hi[i] = 0; since_hi[i] = 0;
            end
            run[i]++;
            if (sck_s[i]) begin sck_hi[i]++; since_hi[i] = 0; end
            else since_hi[i]++;
            if (run[i] <= 4 && sck_s[i]) viol[i]++;
            if (sck_s[i] && !prev_sck[i]) begin
               if (rises[i] < 32) cap[i] = {cap[i][30:0], mosi_s[i]};
               rises[i]++;
            end
         end else begin
            if (run[i] != 0) begin
               last_len[i] = run[i]; last_since[i] = since_hi[i];
               last_sck_hi[i] = sck_hi[i]; txn[i]++; run[i] = 0;
            end
            if (sck_s[i]) viol[i]++;
         end
         if ((mosi_s[i] !== prev_mosi[i]) && sck_s[i]) viol[i]++;
         // Mode-0 flash: next data bit driven after each sck fall past the 32 cmd/addr bits
         if (cs_n_s[i]) begin
            falls[i] = 0; miso_s[i] = 1'b0;
         end else if (!sck_s[i] && prev_sck[i]) begin
            falls[i]++;
            if (falls[i] >= 32) begin
               j = falls[i] - 32;
               miso_s[i] = pat[(j / 8) % 16][7 - (j % 8)];
            end
         end
         if (vld_s[i]) begin
            vectors++;
            assert (data_s[i] === pat[idx[i] % 16]) else begin
               miscompares++;
               $error("FAIL rd_data[%0d] byte %0d observed=%0h expected=%0h", i, idx[i], data_s[i], pat[idx[i] % 16]);
            end
            if (idx[i] == 0) first_vld[i] = cyc;
            else begin
               vectors++;
               assert (cyc - prev_vld[i] == 32) else begin
                  miscompares++;
                  $error("FAIL vld_spacing[%0d] observed=%0d expected=32", i, cyc - prev_vld[i]);
               end
            end
            prev_vld[i] = cyc; idx[i]++; vcnt[i]++;
         end
         prev_sck[i] = sck_s[i]; prev_mosi[i] = mosi_s[i];
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge sys_clk); #1;
      end
   endtask

   task automatic pulse_key(input int i, output int k);
      @(posedge sys_clk); #1;
      k = cyc; key_s[i] = 1'b1;
      @(posedge sys_clk); #1;
      key_s[i] = 1'b0;
   endtask

   task automatic key_at(input int i, input int c);
      wait_until(c);
      key_s[i] = 1'b1;
      @(posedge sys_clk); #1;
      key_s[i] = 1'b0;
   endtask

   int k, kb;

   initial begin
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_cs_n_a", 32'(cs_n_s[0]), 32'd1);
      check("rst_sck_a", 32'(sck_s[0]), 32'd0);
      check("rst_mosi_a", 32'(mosi_s[0]), 32'd0);
      check("rst_rd_data_a", 32'(data_s[0]), 32'h00);
      check("rst_rd_valid_a", 32'(vld_s[0]), 32'd0);
      check("rst_cs_n_b", 32'(cs_n_s[1]), 32'd1);
      @(negedge sys_clk); sys_rst_n = 1'b1;
      repeat (3) @(posedge sys_clk);

      // Transaction 1 with stray keys in CMD, READ and the last HOLD cycle
      pulse_key(0, k);
      check("cs_n_low_k+1", 32'(cs_n_s[0]), 32'd0);
      key_at(0, k + 20);
      key_at(0, k + 300);
      key_at(0, k + 456);
      check("cs_n_idle_k+457", 32'(cs_n_s[0]), 32'd1);
      wait_until(k + 470);
      check("txn1_count", 32'(txn[0]), 32'd1);
      check("txn1_cs_low_len", 32'(last_len[0]), 32'd456);
      check("txn1_vld_count", 32'(vcnt[0]), 32'd10);
      check("txn1_first_vld", 32'(first_vld[0] - k), 32'd164);
      check("txn1_mosi_cmd_addr", cap[0], 32'h03_000000);
      check("txn1_sck_high_cycles", 32'(last_sck_hi[0]), 32'd224);
      check("txn1_hold_sck_low", 32'(last_since[0]), 32'd4);
      check("txn1_rd_data_hold", 32'(data_s[0]), 32'hFF);
      wait_until(k + 700);
      check("no_retrigger_cs_n", 32'(cs_n_s[0]), 32'd1);
      check("no_retrigger_txn", 32'(txn[0]), 32'd1);
      check("no_retrigger_vld", 32'(vcnt[0]), 32'd10);

      // Transaction 2 aborted by reset during the 5th byte
      pulse_key(0, k);
      wait_until(k + 275);
      #4 sys_rst_n = 1'b0;
      #1;
      check("abort_cs_n_async", 32'(cs_n_s[0]), 32'd1);
      check("abort_sck", 32'(sck_s[0]), 32'd0);
      check("abort_rd_data", 32'(data_s[0]), 32'h00);
      check("abort_vld_before", 32'(vcnt[0]), 32'd14);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk); sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      wait_until(cyc + 150);
      check("abort_no_more_vld", 32'(vcnt[0]), 32'd14);
      check("abort_no_restart", 32'(cs_n_s[0]), 32'd1);
      check("abort_txn_count", 32'(txn[0]), 32'd2);

      // Transaction 3: clean after the reset
      pulse_key(0, k);
      wait_until(k + 470);
      check("txn3_count", 32'(txn[0]), 32'd3);
      check("txn3_cs_low_len", 32'(last_len[0]), 32'd456);
      check("txn3_vld_count", 32'(vcnt[0]), 32'd24);
      check("txn3_first_vld", 32'(first_vld[0] - k), 32'd164);
      check("txn3_mosi_cmd_addr", cap[0], 32'h03_000000);

      // Single-byte read at 0x123456
      pulse_key(1, kb);
      wait_until(kb + 190);
      check("b_txn_count", 32'(txn[1]), 32'd1);
      check("b_cs_low_len", 32'(last_len[1]), 32'd168);
      check("b_vld_count", 32'(vcnt[1]), 32'd1);
      check("b_first_vld", 32'(first_vld[1] - kb), 32'd164);
      check("b_mosi_cmd_addr", cap[1], 32'h03_123456);
      check("b_sck_high_cycles", 32'(last_sck_hi[1]), 32'd80);
      check("b_hold_sck_low", 32'(last_since[1]), 32'd4);
      check("b_rd_data", 32'(data_s[1]), 32'hA5);

      check("a_pin_rules", 32'(viol[0]), 32'd0);
      check("b_pin_rules", 32'(viol[1]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
